mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- M-stage data-memory access unit. Sits between the E/M pipeline register outputs and the M/W pipeline register.
- Turns each load/store in M into a req/ack bus transaction, covering DM and timer devices.
- Generates byte enables, detects address exceptions and returns extended load data for W.
- Stalls the pipeline until the bus acknowledges.

Parameters:
- ADDR_LIMIT, 32'h0000_7F1B, highest legal byte address. Any access above it raises an address exception.
- TIMEOUT_CYCLES, 16, cycles spent in WAIT before a bus error. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- addr  input  32  effective address (AO from M stage)
- wdata_in  input  32  store data (rt from M stage)
- mem_rd  input  1  M instruction is a load
- mem_wr  input  1  M instruction is a store
- hbw  input  2  access size: 00 word, 01 half, 10 byte
- dm_ext  input  1  1 = sign-extend load, 0 = zero-extend
- error_in  input  4  exception code from earlier stages; 0 = none
- flush  input  1  CP0 exception/interrupt taken this cycle
- bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}, registered
- bus_wdata  output  32  store data placed on the selected byte lanes, registered
- bus_be  output  4  byte enables, registered
- bus_we  output  1  write strobe, registered
- bus_req  output  1  transaction request, registered
- bus_rdata  input  32  read data, valid when bus_ack is high
- bus_ack  input  1  transaction complete, single cycle
- mem_stall  output  1  freeze PC/F/D/E/M; insert bubble into W
- dr  output  32  extended load data, registered
- exc_out  output  5  exception code for CP0; 0 = none
- bus_err  output  1  timeout occurred (BUS_TIMEOUT_EN only, else 0)

Behaviour:
- Reset (async) sets the following: state IDLE, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, dr 0, bus_err 0, abort flag 0.
- go = (mem_rd|mem_wr) & (error_in==0) & ~addr_err & ~flush.
- addr_err is true when any of these holds:
  - word access with addr[1:0]!=0
  - half access with addr[0]!=0
  - addr > ADDR_LIMIT
  - half or byte store to addr >= 32'h7F00
- exc_out:
  - error_in if error_in != 0
  - else 4 (AdEL) on a load with addr_err
  - else 5 (AdES) on a store with addr_err
  - else 7 if bus_err is set in DONE
  - else 0
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
  - loads use the same bus_be; bus_we is 0.
- Store data: half stores replicate rt[15:0] into both halves; byte stores replicate rt[7:0] into all four lanes.
- States:
  - IDLE: mem_stall = go, combinational. On a clock edge with go, register the bus outputs, set bus_req=1 and move to WAIT.
  - WAIT: mem_stall=1 and bus_req is held.
    - On bus_ack: drop bus_req/bus_we. If the access was a load, latch the extended data into dr. Move to DONE, or to IDLE if abort is set.
  - DONE: mem_stall=0 for exactly one cycle so the pipeline advances. The M instruction is not reissued. Return to IDLE.
- Load extension (dr):
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Extension is sign or zero per dm_ext, using values latched at issue time.
- Latency: ack in the first WAIT cycle gives mem_stall high for 2 cycles, and dr is valid in DONE.
- flush in IDLE blocks the issue.
- flush in WAIT sets abort. The request is still held until ack, so the bus is never left mid-transaction; dr is not updated and DONE is skipped.
- An access with addr_err or error_in!=0 issues nothing and never stalls.
- bus_ack outside WAIT is ignored.
- Reset mid-WAIT drops bus_req immediately.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT. On reaching TIMEOUT_CYCLES without ack: drop bus_req, set bus_err, go to DONE.
  - exc_out = 7 in DONE.
  - bus_err clears on leaving DONE.
  - The counter clears on entry to WAIT.
- When undefined: WAIT lasts until ack, bus_err is tied 0 and no counter logic exists.

Test Plan:
- lw, addr=0x0000_0010, ack 1 cycle after req, bus_rdata=0x8000_00FF -> mem_stall high 2 cycles; bus_be=1111; dr=0x8000_00FF; exc_out=0.
- lb, dm_ext=1, addr=0x0000_0013, bus_rdata=0x80FF_FF7F -> bus_be=1000; dr=0xFFFF_FF80. Repeat with lhu, addr=0x12 -> dr=0x0000_80FF.
- sh, rt=0x1234_ABCD, addr=0x0000_0006 -> bus_we=1; bus_be=1100; bus_wdata=0xABCD_ABCD.
- lw addr=0x0000_0002 -> no bus_req; mem_stall 0; exc_out=4. sb addr=0x0000_7F04 -> exc_out=5.
- flush asserted in the second WAIT cycle of a lw, ack 3 cycles later -> bus_req held until ack; dr unchanged; state returns to IDLE with no DONE cycle.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> bus_req drops after 16 WAIT cycles; bus_err=1 and exc_out=7 for one cycle; mem_stall then 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage data-memory access unit.
// Turns each load/store sitting in M into a single req/ack bus transaction,
// generates byte enables and store lanes, flags address exceptions and
// returns sign/zero-extended load data for W. The pipeline is stalled from
// issue until the bus acknowledges, then released for exactly one cycle.
// Optional feature: define BUS_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT_CYCLES and report a bus error (exc_out = 7) on expiry.
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT     = 32'h0000_7F1B,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  hbw,
    input  logic        dm_ext,
    input  logic [3:0]  error_in,
    input  logic        flush,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        bus_req,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        mem_stall,
    output logic [31:0] dr,
    output logic [4:0]  exc_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] dr_q, dr_d;
    logic        abort_q, abort_d;
    // Access attributes captured at issue so the extension does not depend
    // on whatever the (possibly flushed) M stage holds when ack arrives.
    logic        ld_q, ld_d;
    logic [1:0]  size_q, size_d;
    logic        ext_q, ext_d;
    logic [1:0]  lane_q, lane_d;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    logic        is_word, is_half;
    logic        addr_err, go;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] load_ext;

    // Decode the M-stage access: legality, issue condition, lanes and enables
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        is_word   = (hbw == 2'b00);
        is_half   = (hbw == 2'b01);
        addr_err  = 1'b0;
        if (is_word && addr[1:0] != 2'b00)            addr_err = 1'b1;
        if (is_half && addr[0])                        addr_err = 1'b1;
        if (addr > ADDR_LIMIT)                         addr_err = 1'b1;
        if (mem_wr && !is_word && addr >= 32'h0000_7F00) addr_err = 1'b1;
        go = (mem_rd | mem_wr) & (error_in == 4'd0) & ~addr_err & ~flush;

        if (is_word) begin
            be_new    = 4'b1111;
            wdata_new = wdata_in;
        end else if (is_half) begin
            be_new    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata_in[15:0]}};
        end else begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata_in[7:0]}};
        end
    end

    // Select and extend the returned load lane using the issue-time attributes
    always_comb begin
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_byte = bus_rdata[{lane_q, 3'b000} +: 8];
        if (size_q == 2'b00) begin
            load_ext = bus_rdata;
        end else if (size_q == 2'b01) begin
            load_ext = {{16{ext_q & ld_half[15]}}, ld_half};
        end else begin
            load_ext = {{24{ext_q & ld_byte[7]}}, ld_byte};
        end
    end

    // Next-state logic for the IDLE -> WAIT -> DONE handshake
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_we_d    = bus_we_q;
        bus_req_d   = bus_req_q;
        dr_d        = dr_q;
        abort_d     = abort_q;
        ld_d        = ld_q;
        size_d      = size_q;
        ext_d       = ext_q;
        lane_d      = lane_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = wdata_new;
                    bus_be_d    = be_new;
                    bus_we_d    = mem_wr & ~mem_rd;
                    bus_req_d   = 1'b1;
                    ld_d        = mem_rd;
                    size_d      = hbw;
                    ext_d       = dm_ext;
                    lane_d      = addr[1:0];
                    abort_d     = 1'b0;
`ifdef BUS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // The request stays up after a flush so the bus transaction
                // always completes; only the pipeline-visible result is dropped.
                if (flush) abort_d = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    abort_d   = 1'b0;
                    if (abort_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        if (ld_q) dr_d = load_ext;
                        state_d = S_DONE;
                    end
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    abort_d   = 1'b0;
                    // A flushed access must not raise a bus error afterwards.
                    if (abort_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        bus_err_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef BUS_TIMEOUT_EN
                bus_err_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered bus outputs, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments only; comb blocks use blocking.
        if (reset) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_we_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            dr_q        <= '0;
            abort_q     <= 1'b0;
            ld_q        <= 1'b0;
            size_q      <= 2'b00;
            ext_q       <= 1'b0;
            lane_q      <= 2'b00;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_we_q    <= bus_we_d;
            bus_req_q   <= bus_req_d;
            dr_q        <= dr_d;
            abort_q     <= abort_d;
            ld_q        <= ld_d;
            size_q      <= size_d;
            ext_q       <= ext_d;
            lane_q      <= lane_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

`ifdef BUS_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign bus_we    = bus_we_q;
    assign bus_req   = bus_req_q;
    assign dr        = dr_q;

    // Pipeline stall and exception code presented to CP0
    always_comb begin
        unique case (state_q)
            S_IDLE:  mem_stall = go;
            S_WAIT:  mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase

        if (error_in != 4'd0)                   exc_out = {1'b0, error_in};
        else if (mem_rd && addr_err)            exc_out = 5'd4;
        else if (mem_wr && addr_err)            exc_out = 5'd5;
        else if (state_q == S_DONE && bus_err)  exc_out = 5'd7;
        else                                    exc_out = 5'd0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (default build, BUS_TIMEOUT_EN off).
// A driver plays the pipeline, a responder plays the bus with its own word
// memory, and a monitor compares bus requests and retiring results against
// expectations queued by a byte-level reference model.
module tb_mem_access_unit;

    localparam logic [31:0] ADDR_LIMIT = 32'h0000_7F1B;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata_in, bus_addr, bus_wdata, bus_rdata, dr;
    logic        mem_rd, mem_wr, dm_ext, flush, bus_we, bus_req, bus_ack, mem_stall, bus_err;
    logic [1:0]  hbw;
    logic [3:0]  error_in, bus_be;
    logic [4:0]  exc_out;

    mem_access_unit #(.ADDR_LIMIT(ADDR_LIMIT), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata_in(wdata_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .hbw(hbw), .dm_ext(dm_ext),
        .error_in(error_in), .flush(flush), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
        .bus_req(bus_req), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_stall(mem_stall), .dr(dr), .exc_out(exc_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  exc;
        logic        chk_dr;
        logic [31:0] dr;
    } ret_exp_t;

    bus_exp_t bus_q[$];
    ret_exp_t ret_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model state: a byte-addressed view of memory
    logic [7:0]  shadow  [0:32767];
    // Bus-side memory owned by the responder, updated only through byte enables
    logic [31:0] bus_mem [0:8191];
    logic [31:0] last_dr = 32'd0;
    int          next_delay = 0;

    function automatic logic [31:0] seed_word(input int w);
        logic [31:0] wv;
        wv = 32'(w);
        return (wv * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'b00) return 4;
        if (sz == 2'b01) return 2;
        return 1;
    endfunction

    function automatic bit model_addr_err(input bit is_st, input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = size_bytes(sz);
        if ((a % 32'(n)) != 0)                   return 1'b1;
        if (a > ADDR_LIMIT)                       return 1'b1;
        if (is_st && n < 4 && a >= 32'h7F00)      return 1'b1;
        return 1'b0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        int base;
        base = int'(a[14:2]) * 4;
        bus_mem[a[14:2]] = d;
        for (int i = 0; i < 4; i++) shadow[base + i] = d[8*i +: 8];
    endtask

    // Bus responder: acks each request after next_delay extra WAIT cycles,
    // and throws in stray acks while no request is pending.
    int resp_busy = 0;
    int resp_cnt  = 0;
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (reset || !bus_req) begin
                resp_busy = 0;
                if (!reset && $urandom_range(0, 7) == 0) bus_ack = 1'b1;
            end else begin
                if (resp_busy == 0) begin
                    resp_busy = 1;
                    resp_cnt  = 0;
                end
                if (resp_cnt == next_delay) begin
                    bus_ack = 1'b1;
                    if (bus_we) begin
                        for (int l = 0; l < 4; l++)
                            if (bus_be[l]) bus_mem[bus_addr[14:2]][8*l +: 8] = bus_wdata[8*l +: 8];
                    end else begin
                        bus_rdata = bus_mem[bus_addr[14:2]];
                    end
                end
                resp_cnt++;
            end
        end
    end

    // Monitor: checks each new bus request and each retiring M instruction
    logic     mon_prev_req = 1'b0;
    bus_exp_t mon_b;
    ret_exp_t mon_r;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_req = 1'b0;
            end else begin
                if (bus_req && !mon_prev_req) begin
                    check("bus_req expected", 32'(bus_q.size() != 0), 32'd1);
                    if (bus_q.size() != 0) begin
                        mon_b = bus_q.pop_front();
                        check("bus_addr", bus_addr, mon_b.addr);
                        check("bus_be", 32'(bus_be), 32'(mon_b.be));
                        check("bus_we", 32'(bus_we), 32'(mon_b.we));
                        if (mon_b.we) check("bus_wdata", bus_wdata, mon_b.wdata);
                    end
                end
                mon_prev_req = bus_req;
                if ((mem_rd || mem_wr) && !mem_stall && !flush) begin
                    check("retire expected", 32'(ret_q.size() != 0), 32'd1);
                    if (ret_q.size() != 0) begin
                        mon_r = ret_q.pop_front();
                        check("exc_out", 32'(exc_out), 32'(mon_r.exc));
                        check("bus_err", 32'(bus_err), 32'd0);
                        if (mon_r.chk_dr) check("dr", dr, mon_r.dr);
                    end
                end
            end
        end
    end

    // One M-stage access. flush_mode: 0 none, 1 flush in IDLE, 2 flush in second WAIT cycle.
    task automatic do_access(input bit is_st, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] rt, input bit ext, input logic [3:0] err,
                             input int flush_mode, input int delay);
        int       n, stalls, g;
        bit       aerr, issue;
        bus_exp_t be_e;
        ret_exp_t re_e;
        logic [31:0] v;
        n     = size_bytes(sz);
        aerr  = model_addr_err(is_st, sz, a);
        issue = (err == 4'd0) && !aerr && (flush_mode != 1);
        if (issue) begin
            be_e.addr = a & ~32'd3;
            be_e.be   = 4'b0000;
            for (int i = 0; i < n; i++) be_e.be[int'(a[1:0]) + i] = 1'b1;
            be_e.we    = is_st;
            be_e.wdata = (n == 4) ? rt : (n == 2) ? {2{rt[15:0]}} : {4{rt[7:0]}};
            bus_q.push_back(be_e);
            v = 32'd0;
            if (is_st) begin
                for (int i = 0; i < n; i++) shadow[int'(a) + i] = rt[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[int'(a) + i];
                if (ext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            end
            if (flush_mode == 0) begin
                re_e.exc = 5'd0; re_e.chk_dr = !is_st; re_e.dr = v;
                ret_q.push_back(re_e);
                if (!is_st) last_dr = v;
            end
        end else if (flush_mode != 1) begin
            re_e.exc    = (err != 4'd0) ? {1'b0, err} : (is_st ? 5'd5 : 5'd4);
            re_e.chk_dr = 1'b0;
            re_e.dr     = 32'd0;
            ret_q.push_back(re_e);
        end

        next_delay = (flush_mode == 2) ? 4 : delay;
        mem_rd = !is_st; mem_wr = is_st; hbw = sz; addr = a; wdata_in = rt;
        dm_ext = ext; error_in = err; flush = (flush_mode == 1);

        if (flush_mode == 2) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
            check("req held after flush", 32'(bus_req), 32'd1);
            g = 0;
            while (bus_req && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            check("req released after abort", 32'(bus_req), 32'd0);
            check("dr unchanged by abort", dr, last_dr);
            check("no stall after abort", 32'(mem_stall), 32'd0);
        end else begin
            stalls = 0;
            g = 0;
            forever begin
                @(negedge clk);
                if (!mem_stall || g >= 40) break;
                stalls++;
                g++;
                @(posedge clk);
            end
            check("stall cycles", 32'(stalls), issue ? 32'(delay + 2) : 32'd0);
            @(posedge clk); #1;
        end
        mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0; error_in = 4'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          is_st, ext;
        logic [1:0]  sz;
        logic [31:0] a, rt;
        logic [3:0]  err;
        int          roll, fm, n;

        for (int w = 0; w < 8192; w++) preload(32'(w) << 2, seed_word(w));

        reset = 1'b1; addr = 32'd0; wdata_in = 32'd0; mem_rd = 1'b0; mem_wr = 1'b0;
        hbw = 2'b00; dm_ext = 1'b0; error_in = 4'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_be", 32'(bus_be), 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        check("rst dr", dr, 32'd0);
        check("rst bus_err", 32'(bus_err), 32'd0);
        check("rst mem_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        preload(32'h10, 32'h8000_00FF);
        do_access(1'b0, 2'b00, 32'h10, 32'd0, 1'b0, 4'd0, 0, 0);          // lw
        preload(32'h10, 32'h80FF_FF7F);
        do_access(1'b0, 2'b10, 32'h13, 32'd0, 1'b1, 4'd0, 0, 1);          // lb
        do_access(1'b0, 2'b01, 32'h12, 32'd0, 1'b0, 4'd0, 0, 2);          // lhu
        do_access(1'b1, 2'b01, 32'h06, 32'h1234_ABCD, 1'b0, 4'd0, 0, 0);  // sh
        do_access(1'b0, 2'b00, 32'h06, 32'd0, 1'b1, 4'd0, 0, 0);          // lw after sh
        do_access(1'b0, 2'b00, 32'h02, 32'd0, 1'b0, 4'd0, 0, 0);          // misaligned lw
        do_access(1'b1, 2'b10, 32'h7F04, 32'h55, 1'b0, 4'd0, 0, 0);       // sb in protected range
        do_access(1'b0, 2'b00, 32'h7F1C, 32'd0, 1'b0, 4'd0, 0, 0);        // lw above limit
        do_access(1'b0, 2'b10, 32'h7F1B, 32'd0, 1'b1, 4'd0, 0, 0);        // lb at limit
        do_access(1'b0, 2'b00, 32'h10, 32'd0, 1'b0, 4'd9, 0, 0);          // upstream exception
        do_access(1'b0, 2'b00, 32'h10, 32'd0, 1'b0, 4'd0, 2, 0);          // flush in WAIT
        do_access(1'b0, 2'b00, 32'h14, 32'd0, 1'b0, 4'd0, 1, 0);          // flush in IDLE

        // Randomized accesses
        for (int k = 0; k < 300; k++) begin
            is_st = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 2));
            n     = size_bytes(sz);
            roll  = $urandom_range(0, 99);
            if (roll < 75)      a = 32'($urandom_range(0, 63)) & ~(32'(n) - 32'd1);
            else if (roll < 85) a = 32'($urandom_range(0, 63));
            else if (roll < 93) a = (32'h7EF8 + 32'($urandom_range(0, 39))) & ~(32'(n) - 32'd1);
            else                a = $urandom;
            rt   = $urandom;
            ext  = 1'($urandom_range(0, 1));
            err  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            roll = $urandom_range(0, 99);
            fm   = (roll < 5) ? 1 : (roll < 10) ? 2 : 0;
            if (fm == 2 && (err != 4'd0 || model_addr_err(is_st, sz, a))) fm = 0;
            do_access(is_st, sz, a, rt, ext, err, fm, $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Reset while a load is waiting for its ack
        begin
            bus_exp_t be_e;
            be_e.addr = 32'h20; be_e.be = 4'b1111; be_e.we = 1'b0; be_e.wdata = 32'd0;
            bus_q.push_back(be_e);
            next_delay = 10;
            mem_rd = 1'b1; hbw = 2'b00; addr = 32'h20;
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("req before reset", 32'(bus_req), 32'd1);
            reset = 1'b1;
            #1;
            check("req dropped by reset", 32'(bus_req), 32'd0);
            check("dr cleared by reset", dr, 32'd0);
            mem_rd = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            last_dr = 32'd0;
            repeat (3) @(posedge clk);
            #1;
            check("no req after reset", 32'(bus_req), 32'd0);
        end

        check("bus_q drained", 32'(bus_q.size()), 32'd0);
        check("ret_q drained", 32'(ret_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
